// File: rtl/gemm_tile_sched.sv
// gemm_tile_sched: sequences one convolution-as-GEMM pass through the systolic array.
// Outer loop walks output-channel tiles (n), inner loop walks reduction tiles (k).
// Each k tile runs ifmap preload, then weight streaming, then the array drain. After the
// last k tile of an n tile, the accumulated row goes to the write-back mover, and the
// sequencer waits for that mover to report completion.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        starts a pass (sampled only while idle)
//   wb_done_i      write-back mover finished current n tile (sampled only while waiting)
//   busy_o         high whenever not idle
//   done_o         one-cycle pulse at end of pass
//   preload_o      ifmap preload valid, with ifmap_addr_o
//   stream_o       weight column valid / psum enable, with weight_addr_o
//   acc_first_o    accumulator overwrites instead of adding (k == 0)
//   wb_start_o     one-cycle pulse to the write-back mover
//   k_idx_o        current reduction tile
//   n_idx_o        current output tile
//   perf_busy_o    busy cycle count
//   perf_stall_o   write-back wait cycle count
//
// Optional build macro GEMM_TILE_SCHED_PERF_EN enables the saturating perf counters.
// Without it, both perf ports are tied to 0.
// All outputs come straight from flops. They are loaded from next-state values, so each
// output lines up with the state it describes.

module gemm_tile_sched #(
   parameter int unsigned PE_SIZE   = 14,
   parameter int unsigned K_TILES   = 21,
   parameter int unsigned N_TILES   = 5,
   parameter int unsigned DRAIN_CYC = 27,
   parameter int unsigned IF_ADDR_W = 9,
   parameter int unsigned W_ADDR_W  = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 wb_done_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 preload_o,
   output logic [IF_ADDR_W-1:0] ifmap_addr_o,
   output logic                 stream_o,
   output logic [W_ADDR_W-1:0]  weight_addr_o,
   output logic                 acc_first_o,
   output logic                 wb_start_o,
   output logic [4:0]           k_idx_o,
   output logic [2:0]           n_idx_o,
   output logic [31:0]          perf_busy_o,
   output logic [31:0]          perf_stall_o
);

   localparam int unsigned CNT_W = $clog2((DRAIN_CYC > PE_SIZE) ? DRAIN_CYC : PE_SIZE);

   typedef enum logic [2:0] {
      StIdle, StPreload, StStream, StDrain, StWbReq, StWbWait, StDone
   } state_e;

   state_e               state_q, state_d;
   logic [4:0]           k_q, k_d;
   logic [2:0]           n_q, n_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IF_ADDR_W-1:0] ifmap_addr_q, ifmap_addr_d;
   logic [W_ADDR_W-1:0]  weight_addr_q, weight_addr_d;
   logic                 busy_q, done_q, preload_q, stream_q, acc_first_q, wb_start_q;
   logic                 in_tile_d;

   // Next-state logic for the phase counter and the k/n loops
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StPreload;
               k_d     = '0;
               n_d     = '0;
               cnt_d   = '0;
            end
         end
         StPreload: begin
            if (cnt_q == CNT_W'(PE_SIZE - 1)) begin
               state_d = StStream;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StStream: begin
            if (cnt_q == CNT_W'(PE_SIZE - 1)) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDrain: begin
            if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
               cnt_d = '0;
               if (k_q == 5'(K_TILES - 1)) begin
                  state_d = StWbReq;
               end else begin
                  k_d     = k_q + 5'd1;
                  state_d = StPreload;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StWbReq: state_d = StWbWait;
         StWbWait: begin
            if (wb_done_i) begin
               if (n_q == 3'(N_TILES - 1)) begin
                  state_d = StDone;
               end else begin
                  n_d     = n_q + 3'd1;
                  k_d     = '0;
                  cnt_d   = '0;
                  state_d = StPreload;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Addresses only advance while their strobe is active; otherwise they hold
   always_comb begin
      in_tile_d     = (state_d == StPreload) || (state_d == StStream) || (state_d == StDrain);
      ifmap_addr_d  = ifmap_addr_q;
      weight_addr_d = weight_addr_q;
      if (state_d == StPreload) begin
         ifmap_addr_d = IF_ADDR_W'(k_d) * IF_ADDR_W'(PE_SIZE) + IF_ADDR_W'(cnt_d);
      end
      if (state_d == StStream) begin
         weight_addr_d = (W_ADDR_W'(n_d) * W_ADDR_W'(K_TILES) + W_ADDR_W'(k_d))
                         * W_ADDR_W'(PE_SIZE) + W_ADDR_W'(cnt_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         k_q           <= '0;
         n_q           <= '0;
         cnt_q         <= '0;
         ifmap_addr_q  <= '0;
         weight_addr_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         preload_q     <= 1'b0;
         stream_q      <= 1'b0;
         acc_first_q   <= 1'b0;
         wb_start_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         n_q           <= n_d;
         cnt_q         <= cnt_d;
         ifmap_addr_q  <= ifmap_addr_d;
         weight_addr_q <= weight_addr_d;
         busy_q        <= (state_d != StIdle);
         done_q        <= (state_d == StDone);
         preload_q     <= (state_d == StPreload);
         stream_q      <= (state_d == StStream);
         acc_first_q   <= in_tile_d && (k_d == '0);
         wb_start_q    <= (state_d == StWbReq);
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign preload_o     = preload_q;
   assign stream_o      = stream_q;
   assign acc_first_o   = acc_first_q;
   assign wb_start_o    = wb_start_q;
   assign ifmap_addr_o  = ifmap_addr_q;
   assign weight_addr_o = weight_addr_q;
   assign k_idx_o       = k_q;
   assign n_idx_o       = n_q;

`ifdef GEMM_TILE_SCHED_PERF_EN
   logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
   logic        start_acc;

   // Counters track next state, so the value seen in a cycle includes that cycle
   always_comb begin
      start_acc    = (state_q == StIdle) && start_i;
      perf_busy_d  = perf_busy_q;
      perf_stall_d = perf_stall_q;
      if (start_acc) begin
         perf_busy_d  = 32'd1;
         perf_stall_d = '0;
      end else begin
         if ((state_d != StIdle) && (perf_busy_q != '1)) begin
            perf_busy_d = perf_busy_q + 32'd1;
         end
         if ((state_d == StWbWait) && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_busy_q  <= perf_busy_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_busy_o  = perf_busy_q;
   assign perf_stall_o = perf_stall_q;
`else
   assign perf_busy_o  = '0;
   assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Testbench for gemm_tile_sched. A reference model written as nested tile loops
// builds the expected per-cycle trace of a whole pass. Each trace entry also carries
// randomized ignored inputs, such as start_i pulses while busy and wb_done_i outside the
// wait state. Outputs are sampled on the falling edge.

module tb_gemm_tile_sched;

   localparam int PE = 14;
   localparam int KT = 21;
   localparam int NT = 5;
   localparam int DR = 27;
`ifdef GEMM_TILE_SCHED_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   typedef struct packed {
      logic        start;
      logic        wb_done;
      logic        busy;
      logic        done;
      logic        preload;
      logic        stream;
      logic        acc_first;
      logic        wb_start;
      logic [8:0]  if_addr;
      logic [10:0] w_addr;
      logic [4:0]  k;
      logic [2:0]  n;
      logic [31:0] pbusy;
      logic [31:0] pstall;
   } cyc_t;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic        wb_done_i;
   logic        busy_o, done_o, preload_o, stream_o, acc_first_o, wb_start_o;
   logic [8:0]  ifmap_addr_o;
   logic [10:0] weight_addr_o;
   logic [4:0]  k_idx_o;
   logic [2:0]  n_idx_o;
   logic [31:0] perf_busy_o, perf_stall_o;
   logic [97:0] outs;

   int errors;
   int checks;

   // Reference model state
   cyc_t        exp_q[$];
   logic [8:0]  m_if;
   logic [10:0] m_w;
   logic [4:0]  m_k;
   logic [2:0]  m_n;
   int          m_cb;
   int          m_cs;

   gemm_tile_sched dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .wb_done_i     (wb_done_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .preload_o     (preload_o),
      .ifmap_addr_o  (ifmap_addr_o),
      .stream_o      (stream_o),
      .weight_addr_o (weight_addr_o),
      .acc_first_o   (acc_first_o),
      .wb_start_o    (wb_start_o),
      .k_idx_o       (k_idx_o),
      .n_idx_o       (n_idx_o),
      .perf_busy_o   (perf_busy_o),
      .perf_stall_o  (perf_stall_o)
   );

   assign outs = {busy_o, done_o, preload_o, stream_o, acc_first_o, wb_start_o, ifmap_addr_o,
                  weight_addr_o, k_idx_o, n_idx_o, perf_busy_o, perf_stall_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic rstart();
      return ($urandom_range(0, 3) == 0);
   endfunction

   task automatic reset_model();
      m_if = '0;
      m_w  = '0;
      m_k  = '0;
      m_n  = '0;
      m_cb = 0;
      m_cs = 0;
   endtask

   task automatic emit(input cyc_t e_in, input bit is_wait);
      cyc_t e;
      e = e_in;
      if (e.busy) m_cb++;
      if (is_wait) m_cs++;
      e.if_addr = m_if;
      e.w_addr  = m_w;
      e.pbusy   = PERF_ON ? 32'(m_cb) : 32'd0;
      e.pstall  = PERF_ON ? 32'(m_cs) : 32'd0;
      exp_q.push_back(e);
   endtask

   // Expected trace of one pass: idle cycle with start, all tiles, done, one idle cycle
   task automatic build_pass(input int wb_delay);
      cyc_t e;
      e = '0; e.start = 1'b1; e.wb_done = rbit(); e.k = m_k; e.n = m_n;
      emit(e, 1'b0);
      m_cb = 0;
      m_cs = 0;
      for (int n = 0; n < NT; n++) begin
         for (int k = 0; k < KT; k++) begin
            for (int c = 0; c < 2 * PE + DR; c++) begin
               e = '0; e.start = rstart(); e.wb_done = rbit();
               e.busy = 1'b1; e.acc_first = (k == 0); e.k = 5'(k); e.n = 3'(n);
               if (c < PE) begin
                  e.preload = 1'b1;
                  m_if = 9'(k * PE + c);
               end else if (c < 2 * PE) begin
                  e.stream = 1'b1;
                  m_w = 11'((n * KT + k) * PE + (c - PE));
               end
               emit(e, 1'b0);
            end
         end
         e = '0; e.start = rstart(); e.wb_done = rbit();
         e.busy = 1'b1; e.wb_start = 1'b1; e.k = 5'(KT - 1); e.n = 3'(n);
         emit(e, 1'b0);
         for (int w = 0; w < wb_delay; w++) begin
            e = '0; e.start = rstart(); e.wb_done = (w == wb_delay - 1);
            e.busy = 1'b1; e.k = 5'(KT - 1); e.n = 3'(n);
            emit(e, 1'b1);
         end
      end
      e = '0; e.start = rstart(); e.wb_done = rbit();
      e.busy = 1'b1; e.done = 1'b1; e.k = 5'(KT - 1); e.n = 3'(NT - 1);
      emit(e, 1'b0);
      m_k = 5'(KT - 1);
      m_n = 3'(NT - 1);
      e = '0; e.wb_done = rbit(); e.k = m_k; e.n = m_n;
      emit(e, 1'b0);
   endtask

   // Runs one pass against the model; stop_after > 0 truncates it after that many cycles
   task automatic test_pass(input int wb_delay, input int stop_after);
      cyc_t e, obs;
      int   steps, n_wbs, n_done;
      exp_q.delete();
      build_pass(wb_delay);
      steps = exp_q.size();
      if (stop_after > 0 && stop_after < steps) steps = stop_after;
      n_wbs  = 0;
      n_done = 0;
      for (int i = 0; i < steps; i++) begin
         e   = exp_q[i];
         obs = e;
         obs.busy      = busy_o;
         obs.done      = done_o;
         obs.preload   = preload_o;
         obs.stream    = stream_o;
         obs.acc_first = acc_first_o;
         obs.wb_start  = wb_start_o;
         obs.if_addr   = ifmap_addr_o;
         obs.w_addr    = weight_addr_o;
         obs.k         = k_idx_o;
         obs.n         = n_idx_o;
         obs.pbusy     = perf_busy_o;
         obs.pstall    = perf_stall_o;
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL trace cycle %0d (wb_delay %0d): got=%h want=%h", i, wb_delay, obs, e);
         end
         if (wb_start_o === 1'b1) n_wbs++;
         if (done_o === 1'b1) n_done++;
         start_i   = e.start;
         wb_done_i = e.wb_done;
         @(negedge clk);
      end
      start_i   = 1'b0;
      wb_done_i = 1'b0;
      if (stop_after == 0) begin
         checks++;
         if (n_wbs !== NT) begin
            errors++;
            $display("FAIL wb_start pulse count: got=%0d want=%0d", n_wbs, NT);
         end
         checks++;
         if (n_done !== 1) begin
            errors++;
            $display("FAIL done pulse count: got=%0d want=1", n_done);
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start_i   = 1'b0;
      wb_done_i = 1'b0;
      reset_model();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset outputs: got=%h want=0", outs);
      end
      start_i = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL start during reset: busy got=%b want=0", busy_o);
      end
      start_i = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL idle after reset release: got=%h want=0", outs);
      end
   endtask

   task automatic test_full_pass();
      test_pass(10, 0);
   endtask

   task automatic test_back_to_back();
      test_pass(1, 0);
      test_pass(int'($urandom_range(1, 12)), 0);
   endtask

   task automatic test_reset_mid_pass();
      // 1 start cycle + 14 preload + 5 stream cycles leaves the DUT mid-stream
      test_pass(10, 20);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL async reset mid-stream: got=%h want=0", outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL idle after mid-pass reset cycle %0d: got=%h want=0", i, outs);
         end
         @(negedge clk);
      end
      test_pass(int'($urandom_range(2, 12)), 0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_full_pass();
      test_back_to_back();
      test_reset_mid_pass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
